// File: rtl/memory_access_unit.sv
// Load/store unit between the core memory port and a word-wide byte-enabled SRAM.
// One request at a time: capture, SRAM req/gnt/rvalid handshake, lane alignment, extension, errors.
module memory_access_unit #(
   parameter int DATA_WIDTH      = 32,
   parameter int SRAM_ADDR_WIDTH = 16,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_WIDTH-1:0]      memoryAddress,
   input  logic [DATA_WIDTH-1:0]      memoryDataWrite,
   input  logic [1:0]                 memoryLength,
   input  logic                       load,
   input  logic                       store,
   input  logic                       loadUnsigned,
   output logic [DATA_WIDTH-1:0]      memoryDataRead,
   output logic                       memoryReadValid,
   output logic                       accessError,
   output logic                       busy,
   output logic                       sram_req,
   output logic                       sram_we,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0]      sram_wdata,
   output logic [3:0]                 sram_byteEn,
   input  logic                       sram_gnt,
   input  logic [DATA_WIDTH-1:0]      sram_rdata,
   input  logic                       sram_rvalid
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t                state;
   state_t                nextState;
   logic [CW-1:0]         waitCount;
   logic                  captLoad;
   logic [1:0]            captOffset;
   logic [1:0]            captLength;
   logic                  captUnsigned;
   logic                  request;
   logic                  misaligned;
   logic                  timeoutHit;
   logic [3:0]            laneEn;
   logic [DATA_WIDTH-1:0] alignedData;
   logic                  unusedAddrBits;

   // High address bits alias onto the same SRAM word.
   assign unusedAddrBits = ^memoryAddress[DATA_WIDTH-1:SRAM_ADDR_WIDTH+2];
   assign request        = load | store;
   assign timeoutHit     = (waitCount == LAST_COUNT);

   function automatic logic [31:0] extendLoad(input logic [31:0] word, input logic [1:0] offset,
                                              input logic [1:0] length, input logic isUnsigned);
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = word >> {offset, 3'b000};
      case (length)
         2'd0:    result = {{24{~isUnsigned & shifted[7]}}, shifted[7:0]};
         2'd1:    result = {{16{~isUnsigned & shifted[15]}}, shifted[15:0]};
         default: result = word;
      endcase
      return result;
   endfunction

   // Request decode: alignment check, lane enables and replicated write data
   always_comb begin
      misaligned  = 1'b0;
      laneEn      = 4'b0000;
      alignedData = memoryDataWrite;
      case (memoryLength)
         2'd0: begin
            laneEn      = 4'b0001 << memoryAddress[1:0];
            alignedData = {4{memoryDataWrite[7:0]}};
         end
         2'd1: begin
            misaligned  = memoryAddress[0];
            laneEn      = 4'b0011 << memoryAddress[1:0];
            alignedData = {2{memoryDataWrite[15:0]}};
         end
         default: begin
            misaligned  = |memoryAddress[1:0];
            laneEn      = 4'b1111;
            alignedData = memoryDataWrite;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (request) begin
               nextState = misaligned ? HOLD : REQ;
            end else begin
               nextState = IDLE;
            end
         end
         REQ: begin
            if (sram_gnt) begin
               nextState = captLoad ? WAIT : HOLD;
            end else if (timeoutHit) begin
               nextState = HOLD;
            end else begin
               nextState = REQ;
            end
         end
         WAIT: begin
            if (sram_rvalid || timeoutHit) begin
               nextState = HOLD;
            end else begin
               nextState = WAIT;
            end
         end
         HOLD: begin
            if (!request) begin
               nextState = IDLE;
            end else begin
               nextState = HOLD;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Capture registers, SRAM drive, result registers and the timeout counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         waitCount       <= '0;
         captLoad        <= 1'b0;
         captOffset      <= 2'b00;
         captLength      <= 2'b00;
         captUnsigned    <= 1'b0;
         sram_req        <= 1'b0;
         sram_we         <= 1'b0;
         sram_addr       <= '0;
         sram_wdata      <= '0;
         sram_byteEn     <= 4'b0000;
         memoryDataRead  <= '0;
         memoryReadValid <= 1'b0;
         accessError     <= 1'b0;
         busy            <= 1'b0;
      end else begin
         sram_req <= (nextState == REQ);
         busy     <= (nextState != IDLE);
         // Counter restarts whenever REQ or WAIT is (re)entered
         if ((nextState == state) && ((state == REQ) || (state == WAIT))) begin
            waitCount <= waitCount + CW'(1);
         end else begin
            waitCount <= '0;
         end
         case (state)
            IDLE: begin
               if (request) begin
                  captLoad     <= ~store;
                  captOffset   <= memoryAddress[1:0];
                  captLength   <= memoryLength;
                  captUnsigned <= loadUnsigned;
                  sram_we      <= store;
                  sram_addr    <= memoryAddress[SRAM_ADDR_WIDTH+1:2];
                  sram_wdata   <= alignedData;
                  sram_byteEn  <= store ? laneEn : 4'b0000;
                  if (misaligned) begin
                     accessError     <= 1'b1;
                     memoryReadValid <= ~store;
                     memoryDataRead  <= '0;
                  end
               end
            end
            REQ: begin
               if (!sram_gnt && timeoutHit) begin
                  accessError     <= 1'b1;
                  memoryReadValid <= captLoad;
                  memoryDataRead  <= '0;
               end
            end
            WAIT: begin
               if (sram_rvalid) begin
                  memoryDataRead  <= extendLoad(sram_rdata, captOffset, captLength, captUnsigned);
                  memoryReadValid <= 1'b1;
               end else if (timeoutHit) begin
                  accessError     <= 1'b1;
                  memoryReadValid <= 1'b1;
                  memoryDataRead  <= '0;
               end
            end
            HOLD: begin
               if (!request) begin
                  accessError     <= 1'b0;
                  memoryReadValid <= 1'b0;
                  memoryDataRead  <= '0;
               end
            end
            default: begin
               accessError <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: byte-level reference memory, SRAM responder model,
// directed scenarios followed by randomized loads/stores with random grant/return delays.
module tb_memory_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] memoryAddress;
   logic [31:0] memoryDataWrite;
   logic [1:0]  memoryLength;
   logic        load;
   logic        store;
   logic        loadUnsigned;
   logic [31:0] memoryDataRead;
   logic        memoryReadValid;
   logic        accessError;
   logic        busy;
   logic        sram_req;
   logic        sram_we;
   logic [15:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [3:0]  sram_byteEn;
   logic        sram_gnt;
   logic [31:0] sram_rdata;
   logic        sram_rvalid;

   always #5 clk = ~clk;

   memory_access_unit #(.DATA_WIDTH(32), .SRAM_ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .memoryAddress(memoryAddress), .memoryDataWrite(memoryDataWrite),
      .memoryLength(memoryLength), .load(load), .store(store), .loadUnsigned(loadUnsigned),
      .memoryDataRead(memoryDataRead), .memoryReadValid(memoryReadValid), .accessError(accessError),
      .busy(busy), .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_byteEn(sram_byteEn), .sram_gnt(sram_gnt),
      .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid)
   );

   typedef struct {logic valid; logic err; logic [31:0] data;} result_t;
   typedef struct {logic we; logic [15:0] addr; logic [31:0] wdata; logic [3:0] be;} access_t;

   result_t     resQ[$];
   access_t     accQ[$];
   logic [7:0]  refMem  [0:255];
   logic [7:0]  sramMem [0:255];
   int          checks = 0;
   int          errors = 0;
   int          gntDelayPlan = 0;
   int          rvDelayPlan = 1;
   int          reqAge = 0;
   int          rvCount = 0;
   logic [31:0] rvWord;
   logic        prevEvt = 1'b0;
   result_t     curExp;
   result_t     monExp;
   access_t     gotAcc;
   int          lat;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // SRAM responder: grants after the planned delay, returns read data after the planned delay
   initial begin
      sram_gnt = 1'b0;
      sram_rvalid = 1'b0;
      sram_rdata = 32'h0;
      forever begin
         @(negedge clk);
         sram_gnt = 1'b0;
         sram_rvalid = 1'b0;
         sram_rdata = $urandom;
         if (rvCount > 0) begin
            rvCount--;
            if (rvCount == 0) begin
               sram_rvalid = 1'b1;
               sram_rdata = rvWord;
            end
         end
         if (sram_req) begin
            if (reqAge == gntDelayPlan) begin
               sram_gnt = 1'b1;
               checks++;
               if (accQ.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected sram_req: addr %h we %b", sram_addr, sram_we);
               end else begin
                  gotAcc = accQ.pop_front();
                  check32("sram_we", {31'b0, sram_we}, {31'b0, gotAcc.we});
                  check32("sram_addr", {16'b0, sram_addr}, {16'b0, gotAcc.addr});
                  check32("sram_byteEn", {28'b0, sram_byteEn}, {28'b0, gotAcc.be});
                  if (gotAcc.we) check32("sram_wdata", sram_wdata, gotAcc.wdata);
               end
               for (int j = 0; j < 4; j++) begin
                  if (sram_we && sram_byteEn[j]) sramMem[sram_addr[5:0]*4 + j] = sram_wdata[8*j +: 8];
                  rvWord[8*j +: 8] = sramMem[sram_addr[5:0]*4 + j];
               end
               if (!sram_we) rvCount = rvDelayPlan;
            end
            reqAge++;
         end else begin
            reqAge = 0;
         end
      end
   end

   // Monitor: each new result presentation pops one expectation; held values must stay put
   initial begin
      forever begin
         @(negedge clk);
         if ((memoryReadValid | accessError) && !prevEvt) begin
            checks++;
            if (resQ.size() == 0) begin
               errors++;
               $display("FAIL unexpected result: valid %b err %b data %h", memoryReadValid, accessError, memoryDataRead);
            end else begin
               monExp = resQ.pop_front();
               check32("readValid", {31'b0, memoryReadValid}, {31'b0, monExp.valid});
               check32("accessError", {31'b0, accessError}, {31'b0, monExp.err});
               check32("readData", memoryDataRead, monExp.data);
            end
         end else if ((memoryReadValid | accessError) && prevEvt) begin
            check32("heldData", memoryDataRead, monExp.data);
         end
         prevEvt = memoryReadValid | accessError;
      end
   end

   // Reference model + driver for one transaction
   task automatic doTxn(input logic isStore, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] len, input logic uns, input int gd, input int rd,
                        output int latency);
      int          size;
      int          k;
      int          n;
      logic        mis;
      logic        tout;
      logic [31:0] v;
      access_t     acc;
      size = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
      k    = int'(a[1:0]);
      mis  = (k % size) != 0;
      tout = !mis && ((gd >= TO) || (!isStore && rd > TO));
      gntDelayPlan = gd;
      rvDelayPlan  = rd;
      if (!mis && gd < TO) begin
         acc.we = isStore;
         acc.addr = a[17:2];
         acc.be = 4'b0000;
         for (int j = 0; j < 4; j++) begin
            acc.wdata[8*j +: 8] = d[8*(j % size) +: 8];
            if (isStore && j >= k && j < k + size) acc.be[j] = 1'b1;
         end
         accQ.push_back(acc);
      end
      v = 32'h0;
      if (!mis && !tout) begin
         for (int i = 0; i < size; i++) begin
            if (isStore) refMem[int'(a[7:0]) + i] = d[8*i +: 8];
            v[8*i +: 8] = refMem[int'(a[7:0]) + i];
         end
         if (!uns && size < 4 && v[8*size-1]) begin
            for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
         end
      end
      curExp.valid = !isStore;
      curExp.err   = mis || tout;
      curExp.data  = isStore ? 32'h0 : v;
      if (!isStore || mis || tout) resQ.push_back(curExp);
      memoryAddress = a; memoryDataWrite = d; memoryLength = len; loadUnsigned = uns;
      store = isStore; load = !isStore;
      latency = 0;
      @(negedge clk);
      memoryAddress = $urandom; memoryDataWrite = $urandom;
      memoryLength = 2'($urandom); loadUnsigned = 1'($urandom);
      if (isStore) begin
         store = 1'b0;
      end else begin
         latency = 1;
         while (!memoryReadValid && latency < 60) begin
            @(negedge clk);
            latency++;
         end
         checks++;
         if (!memoryReadValid) begin
            errors++;
            $display("FAIL load completion: no memoryReadValid within %0d cycles", latency);
         end
         repeat ($urandom_range(1, 3)) @(negedge clk);
         load = 1'b0;
      end
      n = 0;
      while (busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      check32("return to idle", {29'b0, busy, memoryReadValid, accessError}, 32'h0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         refMem[i] = 8'($urandom);
         sramMem[i] = refMem[i];
      end
      {refMem[16], refMem[17], refMem[18], refMem[19]} = {8'hBB, 8'hAA, 8'h99, 8'h88};
      for (int i = 16; i < 20; i++) sramMem[i] = refMem[i];
      reset = 1'b0; load = 1'b0; store = 1'b0; loadUnsigned = 1'b0;
      memoryAddress = 32'h0; memoryDataWrite = 32'h0; memoryLength = 2'd0;
      repeat (3) @(negedge clk);
      check32("reset flags", {27'b0, busy, sram_req, memoryReadValid, accessError, sram_we}, 32'h0);
      check32("reset data", memoryDataRead, 32'h0);
      check32("reset sram bus", sram_wdata | {16'b0, sram_addr} | {28'b0, sram_byteEn}, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      doTxn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 1, lat);
      check32("load min latency", lat, 3);
      doTxn(1'b1, 32'h10, 32'h80FF7F01, 2'd2, 1'b0, 1, 1, lat);
      doTxn(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0, 2, lat);
      doTxn(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 2, 1, lat);
      doTxn(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 0, 3, lat);
      doTxn(1'b1, 32'h06, 32'h0000BEEF, 2'd1, 1'b0, 3, 1, lat);
      doTxn(1'b0, 32'h05, 32'h0, 2'd2, 1'b0, 0, 1, lat);
      doTxn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, 6, lat);
      doTxn(1'b1, 32'h24, 32'h12345678, 2'd2, 1'b0, 6, 1, lat);
      doTxn(1'b1, 32'h25, 32'h12345678, 2'd1, 1'b0, 0, 1, lat);

      // Reset while waiting for read data
      gntDelayPlan = 0; rvDelayPlan = 0;
      gotAcc.we = 1'b0; gotAcc.addr = 16'h0008; gotAcc.wdata = 32'h0; gotAcc.be = 4'b0000;
      accQ.push_back(gotAcc);
      memoryAddress = 32'h20; memoryLength = 2'd2; load = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0; load = 1'b0;
      @(negedge clk);
      check32("mid-wait reset flags", {27'b0, busy, sram_req, memoryReadValid, accessError, sram_we}, 32'h0);
      check32("mid-wait reset bus", {16'b0, sram_addr} | {28'b0, sram_byteEn} | memoryDataRead, 32'h0);
      reset = 1'b1;
      @(negedge clk);
      doTxn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1, 2, lat);

      for (int t = 0; t < 300; t++) begin
         doTxn(1'($urandom), ($urandom & 32'hFFFC0000) | 32'($urandom_range(0, 255)), $urandom,
               2'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(1, 4)), lat);
      end

      repeat (10) @(negedge clk);
      check32("leftover expectations", resQ.size() + accQ.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
